// File: rtl/fetch_sequencer_if.sv
// Operand-fetch bus: host request/status, data-memory read port and PE lane write port.
interface fetch_sequencer_if;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 32;

  logic              START;
  logic [1:0]        DIMEN;
  logic [ADDR_W-1:0] BASE_A;
  logic [ADDR_W-1:0] BASE_B;
  logic              MEM_RD_EN;
  logic [ADDR_W-1:0] MEM_ADDR;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              LANE_WE;
  logic [1:0]        LANE_SEL;
  logic              OP_SEL;
  logic [DATA_W-1:0] LANE_WDATA;
  logic              BUSY;
  logic              FETCH_DONE;

  modport master (
    output START, DIMEN, BASE_A, BASE_B, MEM_RDATA,
    input  MEM_RD_EN, MEM_ADDR, LANE_WE, LANE_SEL, OP_SEL, LANE_WDATA, BUSY, FETCH_DONE
  );

  modport slave (
    input  START, DIMEN, BASE_A, BASE_B, MEM_RDATA,
    output MEM_RD_EN, MEM_ADDR, LANE_WE, LANE_SEL, OP_SEL, LANE_WDATA, BUSY, FETCH_DONE
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetches A then B operand vectors from data memory into PE operand registers.
// Define FETCH_PIPE_EN for back-to-back reads; otherwise each read waits for its lane write.
module fetch_sequencer (
  input logic              CLK,
  input logic              RSTN,
  fetch_sequencer_if.slave bus
);
  localparam int unsigned AW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned NW = 3;
  localparam int unsigned LW = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [NW-1:0]   n_q, n_n;
  logic [AW-1:0]   base_a_q, base_a_n;
  logic [AW-1:0]   base_b_q, base_b_n;
  logic [CW-1:0]   total_q, total_n;

  logic            rd_en_q, rd_en_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic            busy_q, busy_n;
  logic            done_q, done_n;
  logic            we_q;
  logic [LW-1:0]   lane_q;
  logic            op_q;
  logic            op_c;
  logic [LW-1:0]   lane_c;

  // Words per operand: DIMEN 3 aliases to 4 lanes.
  function automatic logic [NW-1:0] dimen_words(input logic [1:0] d);
    case (d)
      2'd0:    return NW'(1);
      2'd1:    return NW'(2);
      default: return NW'(4);
    endcase
  endfunction

  assign total_q = CW'({n_q, 1'b0});
  assign total_n = CW'({n_n, 1'b0});

  // Lane/operand of the read issued this cycle, registered into the write one cycle later.
  assign op_c   = (cnt_q >= CW'(n_q));
  assign lane_c = op_c ? LW'(cnt_q - CW'(n_q)) : LW'(cnt_q);

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    n_n      = n_q;
    base_a_n = base_a_q;
    base_b_n = base_b_q;
    rd_en_n  = 1'b0;
    addr_n   = '0;
    busy_n   = 1'b0;
    done_n   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_n  = ISSUE;
          cnt_n    = '0;
          n_n      = dimen_words(bus.DIMEN);
          base_a_n = bus.BASE_A;
          base_b_n = bus.BASE_B;
        end
      end
      ISSUE: begin
`ifdef FETCH_PIPE_EN
        // cnt reaches total on the drain cycle carrying the last lane write
        if (cnt_q == total_q) begin
          state_n = DONE;
        end else begin
          cnt_n = cnt_q + CW'(1);
        end
`else
        state_n = WAIT;
`endif
      end
      WAIT: begin
`ifdef FETCH_PIPE_EN
        state_n = IDLE;
`else
        if (cnt_q == total_q - CW'(1)) begin
          state_n = DONE;
        end else begin
          state_n = ISSUE;
          cnt_n   = cnt_q + CW'(1);
        end
`endif
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    rd_en_n = (state_n == ISSUE) && (cnt_n < total_n);
    if (rd_en_n) begin
      if (cnt_n < CW'(n_n)) begin
        addr_n = base_a_n + AW'(cnt_n);
      end else begin
        addr_n = base_b_n + AW'(cnt_n - CW'(n_n));
      end
    end
    busy_n = (state_n != IDLE);
    done_n = (state_n == DONE);
  end

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      n_q      <= '0;
      base_a_q <= '0;
      base_b_q <= '0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      lane_q   <= '0;
      op_q     <= 1'b0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      n_q      <= n_n;
      base_a_q <= base_a_n;
      base_b_q <= base_b_n;
      rd_en_q  <= rd_en_n;
      addr_q   <= addr_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      we_q     <= rd_en_q;
      lane_q   <= rd_en_q ? lane_c : '0;
      op_q     <= rd_en_q & op_c;
    end
  end

  assign bus.MEM_RD_EN  = rd_en_q;
  assign bus.MEM_ADDR   = addr_q;
  assign bus.LANE_WE    = we_q;
  assign bus.LANE_SEL   = lane_q;
  assign bus.OP_SEL     = op_q;
  assign bus.LANE_WDATA = bus.MEM_RDATA;
  assign bus.BUSY       = busy_q;
  assign bus.FETCH_DONE = done_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer; expected timing follows FETCH_PIPE_EN.
module tb_fetch_sequencer;
  logic CLK = 1'b0;
  logic RSTN;
  always #5 CLK = ~CLK;

  fetch_sequencer_if bus();

  fetch_sequencer dut (
    .CLK  (CLK),
    .RSTN (RSTN),
    .bus  (bus)
  );

  logic [31:0] mem [16];
  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t0       = 0;
  bit rec_on   = 1'b0;
  int rk;

  logic [3:0]  rd_addr [32];
  int          rd_cyc  [32];
  int          n_rd;
  logic [1:0]  wr_lane [32];
  logic        wr_op   [32];
  logic [31:0] wr_data [32];
  int          wr_cyc  [32];
  int          n_wr;
  int          n_done, done_cyc, busy_lo, zviol;

  always @(posedge CLK) cyc <= cyc + 1;

  // Memory returns data one cycle after the read strobe.
  always @(posedge CLK) bus.MEM_RDATA <= bus.MEM_RD_EN ? mem[bus.MEM_ADDR] : 32'h0;

  always @(negedge CLK) begin
    if (rec_on) begin
      rk = cyc - t0;
      if (bus.MEM_RD_EN) begin
        if (n_rd < 32) begin rd_addr[n_rd] = bus.MEM_ADDR; rd_cyc[n_rd] = rk; end
        n_rd++;
      end else if (bus.MEM_ADDR !== 4'h0) zviol++;
      if (bus.LANE_WE) begin
        if (n_wr < 32) begin
          wr_lane[n_wr] = bus.LANE_SEL; wr_op[n_wr] = bus.OP_SEL;
          wr_data[n_wr] = bus.LANE_WDATA; wr_cyc[n_wr] = rk;
        end
        n_wr++;
      end else if (bus.LANE_SEL !== 2'd0 || bus.OP_SEL !== 1'b0) zviol++;
      if (bus.FETCH_DONE) begin
        if (n_done == 0) done_cyc = rk;
        n_done++;
      end
      if (rk >= 1 && n_done == 0 && bus.BUSY !== 1'b1) busy_lo++;
    end
  end

  function automatic int exp_rd(input int j);
`ifdef FETCH_PIPE_EN
    return j + 1;
`else
    return 2 * j + 1;
`endif
  endfunction

  function automatic int exp_done(input int n);
`ifdef FETCH_PIPE_EN
    return 2 * n + 2;
`else
    return 4 * n + 1;
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(negedge CLK); #1; end
  endtask

  // Drives START in cycle 0 and returns just after the negedge of cycle 1.
  task automatic start_fetch(input logic [1:0] d, input logic [3:0] a, input logic [3:0] b);
    @(negedge CLK); #1;
    rec_on = 1'b0;
    n_rd = 0; n_wr = 0; n_done = 0; done_cyc = -1; busy_lo = 0; zviol = 0;
    bus.DIMEN = d; bus.BASE_A = a; bus.BASE_B = b; bus.START = 1'b1;
    t0 = cyc;
    rec_on = 1'b1;
    @(negedge CLK); #1;
    bus.START = 1'b0;
  endtask

  task automatic test_reset;
    RSTN = 1'b1; bus.START = 1'b1; bus.DIMEN = 2'd2; bus.BASE_A = 4'h3; bus.BASE_B = 4'h7;
    tick(3);
    n_checks++; if (bus.MEM_RD_EN !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.MEM_RD_EN); end
    n_checks++; if (bus.MEM_ADDR !== 4'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", bus.MEM_ADDR); end
    n_checks++; if (bus.LANE_WE !== 1'b0) begin n_fail++; $display("FAIL reset_lane_we: got %b want 0", bus.LANE_WE); end
    n_checks++; if (bus.LANE_SEL !== 2'd0) begin n_fail++; $display("FAIL reset_lane_sel: got %0d want 0", bus.LANE_SEL); end
    n_checks++; if (bus.OP_SEL !== 1'b0) begin n_fail++; $display("FAIL reset_op_sel: got %b want 0", bus.OP_SEL); end
    n_checks++; if (bus.BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.BUSY); end
    n_checks++; if (bus.FETCH_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.FETCH_DONE); end
    RSTN = 1'b0; bus.START = 1'b0;
    tick(2);
    n_checks++; if (bus.BUSY !== 1'b0 || bus.MEM_RD_EN !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_ignored: busy %b rd_en %b want 0 0", bus.BUSY, bus.MEM_RD_EN);
    end
  endtask

  task automatic test_basic;
    logic [3:0]  ea [4];
    logic [34:0] ew [4];
    ea = '{4'h2, 4'h3, 4'h8, 4'h9};
    ew = '{{2'd0, 1'b0, 32'd23}, {2'd1, 1'b0, 32'd24}, {2'd0, 1'b1, 32'd63}, {2'd1, 1'b1, 32'd64}};
    start_fetch(2'd1, 4'h2, 4'h8);
    tick(12);
    n_checks++; if (n_rd !== 4) begin n_fail++; $display("FAIL basic_reads: got %0d want 4", n_rd); end
    n_checks++; if (n_wr !== 4) begin n_fail++; $display("FAIL basic_writes: got %0d want 4", n_wr); end
    for (int j = 0; j < 4; j++) begin
      n_checks++; if (rd_addr[j] !== ea[j] || rd_cyc[j] !== exp_rd(j)) begin
        n_fail++; $display("FAIL basic_read%0d: got addr %h cyc %0d want %h %0d", j, rd_addr[j], rd_cyc[j], ea[j], exp_rd(j));
      end
      n_checks++; if ({wr_lane[j], wr_op[j], wr_data[j]} !== ew[j] || wr_cyc[j] !== exp_rd(j) + 1) begin
        n_fail++; $display("FAIL basic_write%0d: got %h cyc %0d want %h %0d", j, {wr_lane[j], wr_op[j], wr_data[j]}, wr_cyc[j], ew[j], exp_rd(j) + 1);
      end
    end
    n_checks++; if (done_cyc !== exp_done(2) || n_done !== 1) begin
      n_fail++; $display("FAIL basic_done: got cyc %0d count %0d want %0d 1", done_cyc, n_done, exp_done(2));
    end
    n_checks++; if (busy_lo !== 0 || zviol !== 0 || bus.BUSY !== 1'b0) begin
      n_fail++; $display("FAIL basic_busy_zero: got busy_lo %0d zviol %0d busy %b want 0 0 0", busy_lo, zviol, bus.BUSY);
    end
  endtask

  task automatic test_wrap;
    logic [3:0] ea [8];
    ea = '{4'hE, 4'hF, 4'h0, 4'h1, 4'h0, 4'h1, 4'h2, 4'h3};
    start_fetch(2'd2, 4'hE, 4'h0);
    tick(22);
    n_checks++; if (n_rd !== 8 || n_wr !== 8) begin n_fail++; $display("FAIL wrap_counts: got rd %0d wr %0d want 8 8", n_rd, n_wr); end
    for (int j = 0; j < 8; j++) begin
      n_checks++; if (rd_addr[j] !== ea[j]) begin n_fail++; $display("FAIL wrap_addr%0d: got %h want %h", j, rd_addr[j], ea[j]); end
      n_checks++; if (wr_lane[j] !== 2'(j % 4) || wr_op[j] !== 1'(j / 4) || wr_data[j] !== mem[ea[j]]) begin
        n_fail++; $display("FAIL wrap_write%0d: got lane %0d op %b data %h want %0d %0d %h", j, wr_lane[j], wr_op[j], wr_data[j], j % 4, j / 4, mem[ea[j]]);
      end
    end
    n_checks++; if (busy_lo !== 0 || done_cyc !== exp_done(4)) begin
      n_fail++; $display("FAIL wrap_busy_done: got busy_lo %0d done %0d want 0 %0d", busy_lo, done_cyc, exp_done(4));
    end
  endtask

  task automatic test_busy_start;
    start_fetch(2'd0, 4'h4, 4'h6);
    bus.START = 1'b1;
    tick(2);
    bus.START = 1'b0;
    tick(10);
    n_checks++; if (n_rd !== 2 || n_done !== 1) begin n_fail++; $display("FAIL busy_start_counts: got rd %0d done %0d want 2 1", n_rd, n_done); end
    n_checks++; if (done_cyc !== exp_done(1)) begin n_fail++; $display("FAIL busy_start_done: got %0d want %0d", done_cyc, exp_done(1)); end
    n_checks++; if (wr_data[0] !== mem[4] || wr_data[1] !== mem[6] || wr_op[1] !== 1'b1) begin
      n_fail++; $display("FAIL busy_start_data: got %h %h op %b want %h %h 1", wr_data[0], wr_data[1], wr_op[1], mem[4], mem[6]);
    end
  endtask

  task automatic test_back_to_back;
    start_fetch(2'd0, 4'h1, 4'h3);
    tick(exp_done(1) - 1);
    n_checks++; if (bus.FETCH_DONE !== 1'b1) begin n_fail++; $display("FAIL b2b_done_pulse: got %b want 1", bus.FETCH_DONE); end
    bus.START = 1'b1; bus.DIMEN = 2'd3;
    tick(1);
    bus.START = 1'b0;
    tick(3);
    n_checks++; if (bus.BUSY !== 1'b0 || n_rd !== 2 || n_done !== 1) begin
      n_fail++; $display("FAIL b2b_start_in_done: got busy %b rd %0d done %0d want 0 2 1", bus.BUSY, n_rd, n_done);
    end
    start_fetch(2'd1, 4'h5, 4'h7);
    tick(12);
    n_checks++; if (n_rd !== 4 || rd_addr[3] !== 4'h8 || n_done !== 1) begin
      n_fail++; $display("FAIL b2b_restart: got rd %0d last %h done %0d want 4 8 1", n_rd, rd_addr[3], n_done);
    end
  endtask

  task automatic test_latch;
    logic [3:0] ea [8];
    ea = '{4'h3, 4'h4, 4'h5, 4'h6, 4'h9, 4'hA, 4'hB, 4'hC};
    start_fetch(2'd3, 4'h3, 4'h9);
    tick(1);
    bus.BASE_A = 4'h5; bus.DIMEN = 2'd0; bus.BASE_B = 4'h0;
    tick(exp_done(4) + 2);
    n_checks++; if (n_rd !== 8 || n_wr !== 8) begin n_fail++; $display("FAIL latch_counts: got rd %0d wr %0d want 8 8", n_rd, n_wr); end
    for (int j = 0; j < 8; j++) begin
      n_checks++; if (rd_addr[j] !== ea[j]) begin n_fail++; $display("FAIL latch_addr%0d: got %h want %h", j, rd_addr[j], ea[j]); end
    end
    n_checks++; if (done_cyc !== exp_done(4)) begin n_fail++; $display("FAIL latch_done: got %0d want %0d", done_cyc, exp_done(4)); end
  endtask

  task automatic test_mid_reset;
    int exp_wr_n, exp_rd_n;
`ifdef FETCH_PIPE_EN
    exp_wr_n = 2; exp_rd_n = 3;
`else
    exp_wr_n = 1; exp_rd_n = 2;
`endif
    start_fetch(2'd2, 4'h0, 4'h4);
    tick(2);
    RSTN = 1'b1;
    tick(1);
    RSTN = 1'b0;
    n_checks++; if ({bus.MEM_RD_EN, bus.MEM_ADDR, bus.LANE_WE, bus.LANE_SEL, bus.OP_SEL, bus.BUSY, bus.FETCH_DONE} !== 11'h0) begin
      n_fail++; $display("FAIL midrst_outputs: got %h want 0", {bus.MEM_RD_EN, bus.MEM_ADDR, bus.LANE_WE, bus.LANE_SEL, bus.OP_SEL, bus.BUSY, bus.FETCH_DONE});
    end
    tick(20);
    n_checks++; if (n_wr !== exp_wr_n || n_rd !== exp_rd_n || n_done !== 0) begin
      n_fail++; $display("FAIL midrst_aborted: got wr %0d rd %0d done %0d want %0d %0d 0", n_wr, n_rd, n_done, exp_wr_n, exp_rd_n);
    end
    start_fetch(2'd2, 4'h0, 4'h4);
    tick(22);
    n_checks++; if (n_rd !== 8 || n_wr !== 8 || done_cyc !== exp_done(4)) begin
      n_fail++; $display("FAIL midrst_refetch: got rd %0d wr %0d done %0d want 8 8 %0d", n_rd, n_wr, done_cyc, exp_done(4));
    end
    n_checks++; if (wr_data[7] !== mem[7] || wr_lane[7] !== 2'd3 || wr_op[7] !== 1'b1) begin
      n_fail++; $display("FAIL midrst_last_write: got %h lane %0d op %b want %h 3 1", wr_data[7], wr_lane[7], wr_op[7], mem[7]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h100 + 32'(i);
    mem[2] = 32'd23; mem[3] = 32'd24; mem[8] = 32'd63; mem[9] = 32'd64;
    RSTN = 1'b1; bus.START = 1'b0; bus.DIMEN = 2'd0; bus.BASE_A = 4'h0; bus.BASE_B = 4'h0;
    test_reset();
    test_basic();
    test_wrap();
    test_busy_start();
    test_back_to_back();
    test_latch();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
